microwave_controller: RTL and testbench

//   Top-level sequencing FSM for the microwave. Accepts keypad digits and start/stop/door inputs.

---
 rtl/microwave_controller.sv | 111 +++++++++++
 tb/tb_microwave_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/microwave_controller.sv
// rtl/microwave_controller.sv - microwave sequencing FSM: keypad entry, cook/pause/done, timer load and clear
module microwave_controller #(
  parameter int MAX_DIGITS  = 3,
  parameter int BEEP_CYCLES = 3,
  parameter int DIGIT_W     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic               load_en,
  output logic [DIGIT_W-1:0] load_digit,
  output logic               count_en,
  output logic               timer_clear_n,
  output logic               mag_on,
  output logic               beep,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_digit_cnt;
  logic [BEEP_W-1:0]  r_beep_cnt;
  logic               r_load_en;
  logic [DIGIT_W-1:0] r_load_digit;
  logic               r_clear_n;
  logic               w_digit_ok;

  // Keypad entry is allowed regardless of door position; only the count limit and BCD range gate it.
  assign w_digit_ok = key_valid && (key_digit <= DIGIT_W'(9)) &&
                      (r_digit_cnt < CNT_W'(MAX_DIGITS));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_digit_cnt  <= '0;
      r_beep_cnt   <= '0;
      r_load_en    <= 1'b0;
      r_load_digit <= '0;
      r_clear_n    <= 1'b1;
    end else begin
      r_load_en <= 1'b0;
      r_clear_n <= 1'b1;
      case (r_state)
        S_IDLE, S_ENTRY: begin
          if (stop_clear) begin
            r_clear_n   <= 1'b0;
            r_digit_cnt <= '0;
            r_state     <= S_IDLE;
          end else if (start && r_state == S_ENTRY) begin
            if (door_closed && !timer_zero) r_state <= S_COOK;
          end else if (!start && w_digit_ok) begin
            r_load_en    <= 1'b1;
            r_load_digit <= key_digit;
            r_digit_cnt  <= r_digit_cnt + CNT_W'(1);
            r_state      <= S_ENTRY;
          end
        end
        S_COOK: begin
          if (stop_clear || !door_closed) r_state <= S_PAUSE;
          else if (timer_zero)            r_state <= S_DONE;
        end
        S_PAUSE: begin
          if (stop_clear) begin
            r_clear_n   <= 1'b0;
            r_digit_cnt <= '0;
            r_state     <= S_IDLE;
          end else if (start && door_closed) begin
            r_state <= S_COOK;
          end
        end
        S_DONE: begin
          if (stop_clear) begin
            r_clear_n   <= 1'b0;
            r_digit_cnt <= '0;
            r_beep_cnt  <= '0;
            r_state     <= S_IDLE;
          end else if (r_beep_cnt == BEEP_W'(BEEP_CYCLES - 1)) begin
            r_digit_cnt <= '0;
            r_beep_cnt  <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count_en      = (r_state == S_COOK);
  assign mag_on        = (r_state == S_COOK);
  assign beep          = (r_state == S_DONE);
  assign load_en       = r_load_en;
  assign load_digit    = r_load_digit;
  assign timer_clear_n = r_clear_n;
  assign state         = r_state;

endmodule

// File: tb/tb_microwave_controller.sv
// tb/tb_microwave_controller.sv - scoreboard bench for microwave_controller
module tb_microwave_controller;

  logic       clock = 1'b0;
  logic       reset_n, key_valid, start, stop_clear, door_closed, timer_zero;
  logic [3:0] key_digit;
  logic       load_en, count_en, timer_clear_n, mag_on, beep;
  logic [3:0] load_digit;
  logic [2:0] state;

  typedef struct {
    bit       is_clear;
    int       digit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  microwave_controller dut (
    .clock(clock), .reset_n(reset_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .timer_zero(timer_zero), .load_en(load_en), .load_digit(load_digit),
    .count_en(count_en), .timer_clear_n(timer_clear_n), .mag_on(mag_on),
    .beep(beep), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_load(input int d);
    exp_t e;
    e.is_clear = 1'b0;
    e.digit = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    exp_t e;
    e.is_clear = 1'b1;
    e.digit = 0;
    exp_q.push_back(e);
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Monitor: every load or clear pulse seen must match the next expected event.
  always @(negedge clock) begin
    if (load_en === 1'b1 || timer_clear_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, load_en} * 16 + int'(load_digit), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", int'(timer_clear_n === 1'b0), int'(e.is_clear));
        if (!e.is_clear) check("load_digit", int'(load_digit), e.digit);
      end
    end
  end

  initial begin
    reset_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
    stop_clear = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;
    cyc(2);
    check("rst_state", int'(state), 0);
    check("rst_load_en", int'(load_en), 0);
    check("rst_load_digit", int'(load_digit), 0);
    check("rst_count_en", int'(count_en), 0);
    check("rst_clear_n", int'(timer_clear_n), 1);
    check("rst_mag_on", int'(mag_on), 0);
    check("rst_beep", int'(beep), 0);
    reset_n = 1'b1;
    cyc();

    push_load(1); key(1);
    check("entry_state", int'(state), 1);
    push_load(9); key(9);
    push_load(9); key(9);
    key(5);
    key(12);
    cyc();
    check("entry_full_state", int'(state), 1);

    timer_zero = 1'b1; pulse_start(); timer_zero = 1'b0;
    check("start_tz_stays", int'(state), 1);

    pulse_start();
    check("cook_state", int'(state), 2);
    check("cook_count_en", int'(count_en), 1);
    check("cook_mag_on", int'(mag_on), 1);

    door_closed = 1'b0; cyc();
    check("door_pause_state", int'(state), 3);
    check("door_pause_count_en", int'(count_en), 0);
    check("door_pause_mag", int'(mag_on), 0);
    pulse_start();
    check("start_door_open_stays", int'(state), 3);
    door_closed = 1'b1; pulse_start();
    check("resume_state", int'(state), 2);
    check("resume_count_en", int'(count_en), 1);

    timer_zero = 1'b1; cyc(); timer_zero = 1'b0;
    check("done_state", int'(state), 4);
    check("done_beep1", int'(beep), 1);
    check("done_mag_off", int'(mag_on), 0);
    cyc();
    check("done_beep2", int'(beep), 1);
    cyc();
    check("done_beep3", int'(beep), 1);
    cyc();
    check("after_done_state", int'(state), 0);
    check("after_done_beep", int'(beep), 0);

    push_load(3); key(3);
    pulse_start();
    check("cook2_state", int'(state), 2);
    stop_clear = 1'b1; timer_zero = 1'b1; cyc();
    stop_clear = 1'b0; timer_zero = 1'b0;
    check("stop_tz_pause", int'(state), 3);
    push_clear();
    stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
    check("clear_state", int'(state), 0);
    check("clear_pulse_low", int'(timer_clear_n), 0);
    cyc();
    check("clear_pulse_end", int'(timer_clear_n), 1);

    key(12);
    check("bad_key_idle", int'(state), 0);
    push_load(7); key(7);
    check("new_entry_state", int'(state), 1);
    push_load(8); key(8);
    push_load(2); key(2);
    key(4);
    cyc();

    pulse_start();
    stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
    check("stop_pause", int'(state), 3);
    pulse_start();
    check("pause_resume", int'(state), 2);
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    check("rst_cook_state", int'(state), 0);
    check("rst_cook_mag", int'(mag_on), 0);
    check("rst_cook_count_en", int'(count_en), 0);

    cyc(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
